// File: rtl/mux_param_reg.sv
// rtl/mux_param_reg.sv - N-channel registered mux with valid/ready handshake and select-error flag
// Optional select-error counter built only when MUX_ERR_CNT_EN is defined.
module mux_param_reg #(
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 2,
  parameter int ERR_CNT_W = 8,
  localparam int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        dout,
  output logic                     sel_err,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  logic              accept;
  logic              mapped;
  logic              mapped_accept;
  logic              unmapped_accept;
  logic [DATA_W-1:0] mux_data;

  // The output slot is free when empty or being drained this cycle.
  assign in_ready        = !out_valid || out_ready;
  assign accept          = in_valid && in_ready;
  assign mapped          = (32'(sel) < NUM_CH);
  assign mapped_accept   = accept && mapped;
  assign unmapped_accept = accept && !mapped;

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (32'(sel) == k) begin
        mux_data = din[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= unmapped_accept;
      if (mapped_accept) begin
        out_valid <= 1'b1;
        dout      <= mux_data;
      end else if (accept || out_ready) begin
        // Unmapped accept or plain drain: the slot empties and dout keeps its last value.
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (unmapped_accept && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_param_reg.sv
// tb/tb_mux_param_reg.sv - directed self-checking bench for mux_param_reg
module tb_mux_param_reg;

`ifdef MUX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [1:0] sel;
  logic [5:0] din;
  logic       in_ready, out_valid, sel_err;
  logic [1:0] dout;
  logic [7:0] err_cnt;
  logic       s_in_ready, s_out_valid, s_sel_err;
  logic [1:0] s_dout;
  logic [1:0] s_err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  mux_param_reg #(.NUM_CH(3), .DATA_W(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .sel_err(sel_err), .err_cnt(err_cnt)
  );

  mux_param_reg #(.NUM_CH(3), .DATA_W(2), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .sel(sel), .din(din),
    .out_valid(s_out_valid), .out_ready(out_ready), .dout(s_dout), .sel_err(s_sel_err),
    .err_cnt(s_err_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0; din = 6'b11_10_01;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (dout !== 2'b00) begin errors++; $display("FAIL rst_dout got %b want 00", dout); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rst_sel_err got %b want 0", sel_err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt); end
    rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL post_rst_sel_err got %b want 0", sel_err); end
    exp_cnt = 0;
  endtask

  task automatic test_stream();
    logic [1:0] exp_d [3] = '{2'b01, 2'b10, 2'b11};
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      step();
      checks++; if (dout !== exp_d[i]) begin errors++; $display("FAIL stream_dout%0d got %b want %b", i, dout, exp_d[i]); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d got %b want 1", i, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", out_valid); end
    checks++; if (dout !== 2'b11) begin errors++; $display("FAIL drain_dout got %b want 11", dout); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    step();
    sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dout !== 2'b10) begin errors++; $display("FAIL bp_dout%0d got %b want 10", i, dout); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got %b want 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b want 0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    step();
    checks++; if (dout !== 2'b01) begin errors++; $display("FAIL bp_next_dout got %b want 01", dout); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %b want 1", out_valid); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_unmapped();
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd2;
    step();
    checks++; if (dout !== 2'b11) begin errors++; $display("FAIL um_load_dout got %b want 11", dout); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL um_load_sel_err got %b want 0", sel_err); end
    sel = 2'd3;
    step();
    exp_cnt++;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL um_valid got %b want 0", out_valid); end
    checks++; if (dout !== 2'b11) begin errors++; $display("FAIL um_dout got %b want 11", dout); end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL um_sel_err got %b want 1", sel_err); end
    checks++; if (err_cnt !== (CNT_EN ? 8'(exp_cnt) : 8'd0)) begin errors++; $display("FAIL um_err_cnt got %0d want %0d", err_cnt, CNT_EN ? exp_cnt : 0); end
    in_valid = 1'b0;
    step();
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL um_pulse_end got %b want 0", sel_err); end
    checks++; if (dout !== 2'b11) begin errors++; $display("FAIL um_dout_hold got %b want 11", dout); end
  endtask

  task automatic test_saturate();
    int exp_sat;
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b1; sel = 2'd3; out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_sat = (i > 3) ? 3 : i;
      checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL sat_sel_err%0d got %b want 1", i, sel_err); end
      checks++; if (err_cnt !== (CNT_EN ? 8'(i) : 8'd0)) begin errors++; $display("FAIL sat_cnt8_%0d got %0d want %0d", i, err_cnt, CNT_EN ? i : 0); end
      checks++; if (s_err_cnt !== (CNT_EN ? 2'(exp_sat) : 2'd0)) begin errors++; $display("FAIL sat_cnt2_%0d got %0d want %0d", i, s_err_cnt, CNT_EN ? exp_sat : 0); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_valid%0d got %b want 0", i, out_valid); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rh_valid got %b want 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rh_ready got %b want 0", in_ready); end
    rst = 1'b1; sel = 2'd3;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rh_rst_valid got %b want 0", out_valid); end
    checks++; if (dout !== 2'b00) begin errors++; $display("FAIL rh_rst_dout got %b want 00", dout); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rh_rst_err_cnt got %0d want 0", err_cnt); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rh_rst_sel_err got %b want 0", sel_err); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rh_discard_valid got %b want 0", out_valid); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rh_after_sel_err got %b want 0", sel_err); end
    checks++; if (dout !== 2'b00) begin errors++; $display("FAIL rh_after_dout got %b want 00", dout); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_unmapped();
    test_saturate();
    test_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
